// File: rtl/mouse_host_transmitter.sv
// mouse_host_transmitter: host-to-device PS/2 transmitter that sends one command byte to the mouse.
// It drives the open-collector mouse pads only through output enables.
// Ports:
//   CLK, RESET          system clock; asynchronous active-low reset
//   CLK_MOUSE_IN        raw mouse clock pad level
//   DATA_MOUSE_IN       raw mouse data pad level
//   CLK_MOUSE_OUT_EN    1 pulls the mouse clock low, 0 releases it
//   DATA_MOUSE_OUT_EN   1 pulls mouse data low, 0 releases it
//   SEND_BYTE           one-cycle request, honoured only when idle
//   BYTE_TO_SEND        command byte, latched on an accepted request
//   BUSY                high while a transfer is in progress
//   BYTE_SENT           one-cycle pulse: frame done and acknowledged by the mouse
//   ERROR               one-cycle pulse: NACK or timeout
module mouse_host_transmitter #(
   parameter int unsigned INHIBIT_CYCLES = 6000,
   parameter int unsigned REQ_CYCLES     = 100,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       CLK_MOUSE_IN,
   input  logic       DATA_MOUSE_IN,
   output logic       CLK_MOUSE_OUT_EN,
   output logic       DATA_MOUSE_OUT_EN,
   input  logic       SEND_BYTE,
   input  logic [7:0] BYTE_TO_SEND,
   output logic       BUSY,
   output logic       BYTE_SENT,
   output logic       ERROR
);

   localparam logic [12:0] InhibitLast = 13'(INHIBIT_CYCLES - 1);
   localparam logic [12:0] ReqLast     = 13'(REQ_CYCLES - 1);
   localparam logic [19:0] TmoLast     = 20'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      StIdle,
      StInhibit,
      StReq,
      StSend,
      StWaitAck,
      StWaitIdle
   } state_e;

   state_e      state_q, state_d;
   logic [9:0]  frame_q, frame_d;
   logic [12:0] cnt_q, cnt_d;
   logic [19:0] tmo_q, tmo_d;
   logic [3:0]  bitcnt_q, bitcnt_d;
   logic        data_bit_q, data_bit_d;
   logic        byte_sent_q, byte_sent_d;
   logic        error_q, error_d;
   logic [1:0]  clk_sync_q, data_sync_q;
   logic        clk_prev_q;

   logic clk_synced, data_synced, clk_fall;

   assign clk_synced  = clk_sync_q[1];
   assign data_synced = data_sync_q[1];
   assign clk_fall    = clk_prev_q & ~clk_synced;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         // Synchronizers reset to the idle-high line level so no false edge is seen.
         clk_sync_q  <= 2'b11;
         data_sync_q <= 2'b11;
         clk_prev_q  <= 1'b1;
         state_q     <= StIdle;
         frame_q     <= '0;
         cnt_q       <= '0;
         tmo_q       <= '0;
         bitcnt_q    <= '0;
         data_bit_q  <= 1'b0;
         byte_sent_q <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         clk_sync_q  <= {clk_sync_q[0], CLK_MOUSE_IN};
         data_sync_q <= {data_sync_q[0], DATA_MOUSE_IN};
         clk_prev_q  <= clk_synced;
         state_q     <= state_d;
         frame_q     <= frame_d;
         cnt_q       <= cnt_d;
         tmo_q       <= tmo_d;
         bitcnt_q    <= bitcnt_d;
         data_bit_q  <= data_bit_d;
         byte_sent_q <= byte_sent_d;
         error_q     <= error_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      frame_d     = frame_q;
      cnt_d       = cnt_q;
      tmo_d       = tmo_q;
      bitcnt_d    = bitcnt_q;
      data_bit_d  = data_bit_q;
      byte_sent_d = 1'b0;
      error_d     = 1'b0;
      unique case (state_q)
         StIdle: begin
            // A request landing on the done/error pulse cycle is dropped.
            if (SEND_BYTE && !byte_sent_q && !error_q) begin
               frame_d = {1'b1, ~^BYTE_TO_SEND, BYTE_TO_SEND};
               cnt_d   = '0;
               state_d = StInhibit;
            end
         end
         StInhibit: begin
            if (cnt_q == InhibitLast) begin
               cnt_d   = '0;
               state_d = StReq;
            end else begin
               cnt_d = cnt_q + 13'd1;
            end
         end
         StReq: begin
            if (cnt_q == ReqLast) begin
               cnt_d      = '0;
               bitcnt_d   = '0;
               tmo_d      = '0;
               data_bit_d = 1'b1;  // keep the start bit on data after clock release
               state_d    = StSend;
            end else begin
               cnt_d = cnt_q + 13'd1;
            end
         end
         StSend, StWaitAck, StWaitIdle: begin
            // One timeout spans the whole device-clocked part of the frame.
            tmo_d = tmo_q + 20'd1;
            if (tmo_q == TmoLast) begin
               error_d = 1'b1;
               state_d = StIdle;
            end else if (state_q == StSend) begin
               if (clk_fall) begin
                  data_bit_d = ~frame_q[bitcnt_q];
                  bitcnt_d   = bitcnt_q + 4'd1;
                  if (bitcnt_q == 4'd9) begin
                     state_d = StWaitAck;
                  end
               end
            end else if (state_q == StWaitAck) begin
               if (clk_fall) begin
                  if (data_synced) begin
                     error_d = 1'b1;
                     state_d = StIdle;
                  end else begin
                     state_d = StWaitIdle;
                  end
               end
            end else if (clk_synced && data_synced) begin
               byte_sent_d = 1'b1;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Pad enables decode straight from state so an asynchronous reset releases them at once.
   assign CLK_MOUSE_OUT_EN  = (state_q == StInhibit) || (state_q == StReq);
   assign DATA_MOUSE_OUT_EN = (state_q == StReq) || ((state_q == StSend) && data_bit_q);
   assign BUSY              = (state_q != StIdle);
   assign BYTE_SENT         = byte_sent_q;
   assign ERROR             = error_q;

endmodule

// File: tb/tb_mouse_host_transmitter.sv
// tb_mouse_host_transmitter: directed bench for mouse_host_transmitter with a small PS/2 device model.
// Ports: none (top-level bench).
module tb_mouse_host_transmitter;

   localparam int unsigned INH  = 60;
   localparam int unsigned REQ  = 10;
   localparam int unsigned TMO  = 3000;
   localparam int          HALF = 20;  // device clock half period in CLK cycles

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       send_byte = 1'b0;
   logic [7:0] byte_to_send = 8'h00;
   logic       clk_oe, data_oe, busy, byte_sent, error;
   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;
   logic       clk_pad, data_pad;

   int checks = 0;
   int errors = 0;
   int sent_cnt = 0;
   int err_cnt = 0;
   logic err_lines_ok = 1'b0;

   assign clk_pad  = !(clk_oe || dev_clk_low);
   assign data_pad = !(data_oe || dev_data_low);

   mouse_host_transmitter #(
      .INHIBIT_CYCLES(INH),
      .REQ_CYCLES    (REQ),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .CLK              (clk),
      .RESET            (rst_n),
      .CLK_MOUSE_IN     (clk_pad),
      .DATA_MOUSE_IN    (data_pad),
      .CLK_MOUSE_OUT_EN (clk_oe),
      .DATA_MOUSE_OUT_EN(data_oe),
      .SEND_BYTE        (send_byte),
      .BYTE_TO_SEND     (byte_to_send),
      .BUSY             (busy),
      .BYTE_SENT        (byte_sent),
      .ERROR            (error)
   );

   always #5 clk = ~clk;

   // Count every cycle each pulse is high; one frame must give exactly one.
   always @(negedge clk) begin
      if (byte_sent === 1'b1) sent_cnt <= sent_cnt + 1;
      if (error === 1'b1) begin
         err_cnt      <= err_cnt + 1;
         err_lines_ok <= (clk_oe === 1'b0) && (data_oe === 1'b0) && (busy === 1'b0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_req(input logic [7:0] b);
      send_byte    = 1'b1;
      byte_to_send = b;
      tick();
      send_byte    = 1'b0;
   endtask

   // Device side of one frame: measures host hold time, clocks 10 bits, then ACKs or NACKs.
   task automatic device_frame(input bit ack, output logic [10:0] seen, output int low_cycles,
                               output int req_cycles);
      low_cycles = 0;
      req_cycles = 0;
      seen       = '0;
      while (clk_oe === 1'b1 && low_cycles < 5000) begin
         low_cycles++;
         if (data_oe === 1'b1) req_cycles++;
         tick();
      end
      if (low_cycles >= 5000) begin
         checks++;
         errors++;
         $display("FAIL clk_release_wait: got no release expected release");
      end
      seen[0] = data_pad;
      repeat (HALF) tick();
      for (int i = 1; i <= 10; i++) begin
         dev_clk_low = 1'b1;
         repeat (HALF) tick();
         seen[i]     = data_pad;
         dev_clk_low = 1'b0;
         repeat (HALF) tick();
      end
      dev_data_low = ack;
      repeat (HALF) tick();
      dev_clk_low = 1'b1;
      repeat (HALF) tick();
      dev_clk_low = 1'b0;
      repeat (4) tick();
      dev_data_low = 1'b0;
      repeat (10) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      checks++; if (clk_oe !== 1'b0) begin errors++; $display("FAIL reset_clk_oe: got %b expected 0", clk_oe); end
      checks++; if (data_oe !== 1'b0) begin errors++; $display("FAIL reset_data_oe: got %b expected 0", data_oe); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (byte_sent !== 1'b0) begin errors++; $display("FAIL reset_byte_sent: got %b expected 0", byte_sent); end
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", error); end
      rst_n = 1'b1;
      repeat (3) tick();
   endtask

   task automatic test_send_f4();
      logic [10:0] seen;
      int low, req, s0, e0;
      s0 = sent_cnt;
      e0 = err_cnt;
      send_req(8'hF4);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL f4_busy_next: got %b expected 1", busy); end
      device_frame(1'b1, seen, low, req);
      checks++; if (low != 70) begin errors++; $display("FAIL f4_clk_low: got %0d expected 70", low); end
      checks++; if (req != 10) begin errors++; $display("FAIL f4_req_low: got %0d expected 10", req); end
      // start 0, data 0,0,1,0,1,1,1,1, parity 0, stop 1
      checks++; if (seen !== 11'b10_1111_0100_0) begin errors++; $display("FAIL f4_bits: got %b expected 10111101000", seen); end
      checks++; if (sent_cnt - s0 != 1) begin errors++; $display("FAIL f4_sent: got %0d expected 1", sent_cnt - s0); end
      checks++; if (err_cnt - e0 != 0) begin errors++; $display("FAIL f4_error: got %0d expected 0", err_cnt - e0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL f4_busy_end: got %b expected 0", busy); end
   endtask

   task automatic test_parity();
      logic [10:0] seen;
      int low, req, s0;
      s0 = sent_cnt;
      send_req(8'hFF);
      device_frame(1'b1, seen, low, req);
      checks++; if (seen !== 11'b11_1111_1111_0) begin errors++; $display("FAIL ff_bits: got %b expected 11111111110", seen); end
      checks++; if (sent_cnt - s0 != 1) begin errors++; $display("FAIL ff_sent: got %0d expected 1", sent_cnt - s0); end
      s0 = sent_cnt;
      send_req(8'h00);
      device_frame(1'b1, seen, low, req);
      checks++; if (seen !== 11'b11_0000_0000_0) begin errors++; $display("FAIL 00_bits: got %b expected 11000000000", seen); end
      checks++; if (sent_cnt - s0 != 1) begin errors++; $display("FAIL 00_sent: got %0d expected 1", sent_cnt - s0); end
   endtask

   task automatic test_nack();
      logic [10:0] seen;
      int low, req, s0, e0;
      s0 = sent_cnt;
      e0 = err_cnt;
      send_req(8'hF4);
      device_frame(1'b0, seen, low, req);
      checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL nack_error: got %0d expected 1", err_cnt - e0); end
      checks++; if (sent_cnt - s0 != 0) begin errors++; $display("FAIL nack_sent: got %0d expected 0", sent_cnt - s0); end
      checks++; if (err_lines_ok !== 1'b1) begin errors++; $display("FAIL nack_lines: got %b expected 1", err_lines_ok); end
   endtask

   task automatic test_timeout();
      int n, w;
      send_req(8'hF4);
      w = 0;
      while (clk_oe === 1'b1 && w < 500) begin w++; tick(); end
      n = 0;
      while (error !== 1'b1 && n < 2 * TMO) begin tick(); n++; end
      checks++; if (n != TMO) begin errors++; $display("FAIL timeout_cycles: got %0d expected %0d", n, TMO); end
      checks++; if (clk_oe !== 1'b0) begin errors++; $display("FAIL timeout_clk_oe: got %b expected 0", clk_oe); end
      checks++; if (data_oe !== 1'b0) begin errors++; $display("FAIL timeout_data_oe: got %b expected 0", data_oe); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b expected 0", busy); end
      repeat (5) tick();
   endtask

   task automatic test_ignore();
      logic [10:0] seen;
      int low, req, s0;
      s0 = sent_cnt;
      send_req(8'hF4);
      fork
         device_frame(1'b1, seen, low, req);
         begin
            repeat (20) tick();
            send_req(8'h55);
            repeat (150) tick();
            send_req(8'h55);
         end
      join
      checks++; if (seen !== 11'b10_1111_0100_0) begin errors++; $display("FAIL ignore_bits: got %b expected 10111101000", seen); end
      checks++; if (sent_cnt - s0 != 1) begin errors++; $display("FAIL ignore_sent: got %0d expected 1", sent_cnt - s0); end
      repeat (20) tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_no_queue: got %b expected 0", busy); end
   endtask

   task automatic test_reset_mid_send();
      logic [10:0] seen;
      int low, req, s0, w;
      send_req(8'hF4);
      w = 0;
      while (clk_oe === 1'b1 && w < 500) begin w++; tick(); end
      repeat (HALF) tick();
      for (int i = 0; i < 4; i++) begin
         dev_clk_low = 1'b1;
         repeat (HALF) tick();
         dev_clk_low = 1'b0;
         repeat (HALF) tick();
      end
      // bit 3 of 0xF4 is 0, so data is being pulled low here
      checks++; if (data_oe !== 1'b1) begin errors++; $display("FAIL mid_data_oe_pre: got %b expected 1", data_oe); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (clk_oe !== 1'b0) begin errors++; $display("FAIL mid_clk_oe: got %b expected 0", clk_oe); end
      checks++; if (data_oe !== 1'b0) begin errors++; $display("FAIL mid_data_oe: got %b expected 0", data_oe); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (5) tick();
      s0 = sent_cnt;
      send_req(8'hF4);
      device_frame(1'b1, seen, low, req);
      checks++; if (seen !== 11'b10_1111_0100_0) begin errors++; $display("FAIL mid_after_bits: got %b expected 10111101000", seen); end
      checks++; if (sent_cnt - s0 != 1) begin errors++; $display("FAIL mid_after_sent: got %0d expected 1", sent_cnt - s0); end
   endtask

   initial begin
      test_reset();
      test_send_f4();
      test_parity();
      test_nack();
      test_timeout();
      test_ignore();
      test_reset_mid_send();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
